// File: rtl/denise_pkg.sv
// Shared definitions for the Denise bitplane loader: register word addresses,
// fetch-mode encodings and the plane left-justification used at write time.
package denise_pkg;

    // Word addresses as seen on reg_address_in[8:1] (byte address >> 1).
    localparam logic [7:0] ADDR_BPLCON0 = 8'h80;
    localparam logic [7:0] ADDR_BPLCON1 = 8'h81;
    localparam logic [7:0] ADDR_BPL1DAT = 8'h88;
    localparam logic [7:0] ADDR_FMODE   = 8'hFE;

    localparam int NUM_PLANES = 8;

    typedef enum logic [1:0] {
        FMODE_16  = 2'b00,
        FMODE_32A = 2'b01,
        FMODE_32B = 2'b10,
        FMODE_64  = 2'b11
    } fmode_e;

    // Fetched words are placed at the MSB end so shifters always start from bit 63.
    function automatic logic [63:0] align_plane(input logic [1:0] fm, input logic [63:0] d);
        logic [63:0] r;
        case (fm)
            FMODE_16:             r = {d[15:0], 48'b0};
            FMODE_32A, FMODE_32B: r = {d[31:0], 32'b0};
            default:              r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/denise_bitplane_stage.sv
// One plane's staging register; data is left-justified with the fetch mode
// in force at the moment of the write.
module denise_bitplane_stage
    import denise_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [1:0]  fmode_i,
    input  logic [63:0] data_i,
    output logic [63:0] plane_o
);

    logic [63:0] plane_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            plane_q <= '0;
        end else if (we_i) begin
            plane_q <= align_plane(fmode_i, data_i);
        end
    end

    assign plane_o = plane_q;

endmodule

// File: rtl/denise_bitplane_loader.sv
// Captures bitplane control/data writes, snapshots all planes one clock after a
// BPL1DAT write and issues a single phase-aligned parallel-load strobe.
module denise_bitplane_loader
    import denise_pkg::*;
#(
    parameter int AGA = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clk7_en,
    input  logic         c1,
    input  logic         c3,
    input  logic [8:1]   reg_address_in,
    input  logic [63:0]  data_in,
    output logic [511:0] bpldata,
    output logic         load,
    output logic [7:0]   scroll_odd,
    output logic [7:0]   scroll_even,
    output logic         hires,
    output logic         shres,
    output logic [1:0]   fmode,
    output logic [3:0]   nplanes
);

    localparam logic [7:0] SCROLL_MASK = (AGA != 0) ? 8'hFF : 8'h3C;
    localparam logic [3:0] BPU_LIMIT   = (AGA != 0) ? 4'd8 : 4'd6;

    logic         wr_con0, wr_con1, wr_fmode, wr_bpl, wr_bpl1;
    logic [2:0]   bpl_idx;
    logic [63:0]  stage_data [NUM_PLANES];

    logic [511:0] bpldata_q, bpldata_d;
    logic         snap_q;
    logic         pending_q, pending_d;
    logic [7:0]   scroll_odd_q, scroll_even_q;
    logic         hires_q, shres_q;
    logic [1:0]   fmode_q;
    logic [3:0]   nplanes_q;

    function automatic logic [3:0] decode_bpu(input logic [15:0] d);
        logic [3:0] raw;
        raw = {(AGA != 0) && d[4], d[14:12]};
        return (raw > BPU_LIMIT) ? BPU_LIMIT : raw;
    endfunction

    assign wr_con0  = clk7_en && (reg_address_in == ADDR_BPLCON0);
    assign wr_con1  = clk7_en && (reg_address_in == ADDR_BPLCON1);
    assign wr_fmode = clk7_en && (reg_address_in == ADDR_FMODE);
    assign wr_bpl   = clk7_en && (reg_address_in[8:4] == ADDR_BPL1DAT[7:3]);
    assign bpl_idx  = reg_address_in[3:1];
    assign wr_bpl1  = wr_bpl && (bpl_idx == 3'd0);

    for (genvar n = 0; n < NUM_PLANES; n++) begin : g_stage
        denise_bitplane_stage u_stage (
            .clk     (clk),
            .reset   (reset),
            .we_i    (wr_bpl && (bpl_idx == 3'(n))),
            .fmode_i (fmode_q),
            .data_i  (data_in),
            .plane_o (stage_data[n])
        );
    end

    // A fresh snapshot re-arms pending even on the clock that consumes the previous load.
    always_comb begin
        bpldata_d = bpldata_q;
        pending_d = snap_q | (pending_q & ~load);
        if (snap_q) begin
            for (int n = 0; n < NUM_PLANES; n++) begin
                bpldata_d[64*n +: 64] = (4'(n) < nplanes_q) ? stage_data[n] : 64'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bpldata_q     <= '0;
            snap_q        <= 1'b0;
            pending_q     <= 1'b0;
            scroll_odd_q  <= '0;
            scroll_even_q <= '0;
            hires_q       <= 1'b0;
            shres_q       <= 1'b0;
            fmode_q       <= '0;
            nplanes_q     <= '0;
        end else begin
            bpldata_q <= bpldata_d;
            snap_q    <= wr_bpl1;
            pending_q <= pending_d;
            if (wr_con0) begin
                hires_q   <= data_in[15];
                shres_q   <= (AGA != 0) && data_in[6];
                nplanes_q <= decode_bpu(data_in[15:0]);
            end
            if (wr_con1) begin
                scroll_odd_q  <= {data_in[11:10], data_in[3:0], data_in[9:8]} & SCROLL_MASK;
                scroll_even_q <= {data_in[15:14], data_in[7:4], data_in[13:12]} & SCROLL_MASK;
            end
            if (wr_fmode && (AGA != 0)) begin
                fmode_q <= data_in[1:0];
            end
        end
    end

    assign load        = pending_q & ~c1 & ~c3;
    assign bpldata     = bpldata_q;
    assign scroll_odd  = scroll_odd_q;
    assign scroll_even = scroll_even_q;
    assign hires       = hires_q;
    assign shres       = shres_q;
    assign fmode       = fmode_q;
    assign nplanes     = nplanes_q;

endmodule

// File: tb/tb_denise_bitplane_loader.sv
// Bench for denise_bitplane_loader: an AGA and an OCS instance share the bus,
// each with its own clk7_en; load events are checked against expected snapshots.
module tb_denise_bitplane_loader;

    localparam logic [7:0] A_CON0 = 8'h80;
    localparam logic [7:0] A_CON1 = 8'h81;
    localparam logic [7:0] A_CON3 = 8'h83;
    localparam logic [7:0] A_BPL1 = 8'h88;
    localparam logic [7:0] A_BPL2 = 8'h89;
    localparam logic [7:0] A_BPL3 = 8'h8A;
    localparam logic [7:0] A_BPL6 = 8'h8D;
    localparam logic [7:0] A_BPL7 = 8'h8E;
    localparam logic [7:0] A_BPL8 = 8'h8F;
    localparam logic [7:0] A_FMOD = 8'hFE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en_a = 1'b0;
    logic        en_o = 1'b0;
    logic        c1 = 1'b1;
    logic        c3 = 1'b0;
    logic [1:0]  ph = 2'd0;
    logic [7:0]  addr = 8'h00;
    logic [63:0] data = 64'h0;

    logic [511:0] bpl_a, bpl_o;
    logic         load_a, load_o, hires_a, hires_o, shres_a, shres_o;
    logic [7:0]   so_a, se_a, so_o, se_o;
    logic [1:0]   fm_a, fm_o;
    logic [3:0]   np_a, np_o;

    int n_checks = 0;
    int n_fail = 0;
    logic [511:0] exp_a_q[$];
    logic [511:0] exp_o_q[$];

    denise_bitplane_loader #(.AGA(1)) dut_a (
        .clk(clk), .reset(reset), .clk7_en(en_a), .c1(c1), .c3(c3),
        .reg_address_in(addr), .data_in(data), .bpldata(bpl_a), .load(load_a),
        .scroll_odd(so_a), .scroll_even(se_a), .hires(hires_a), .shres(shres_a),
        .fmode(fm_a), .nplanes(np_a)
    );

    denise_bitplane_loader #(.AGA(0)) dut_o (
        .clk(clk), .reset(reset), .clk7_en(en_o), .c1(c1), .c3(c3),
        .reg_address_in(addr), .data_in(data), .bpldata(bpl_o), .load(load_o),
        .scroll_odd(so_o), .scroll_even(se_o), .hires(hires_o), .shres(shres_o),
        .fmode(fm_o), .nplanes(np_o)
    );

    always #5 clk = ~clk;

    // Four-phase sequence; c1=c3=0 only during phase 3.
    initial forever begin
        @(posedge clk);
        #1;
        ph = ph + 2'd1;
        c1 = (ph == 2'd0) || (ph == 2'd1);
        c3 = (ph == 2'd1) || (ph == 2'd2);
    end

    function automatic logic [63:0] pl(input logic [15:0] w);
        return {w, 48'h0};
    endfunction

    function automatic logic [511:0] mk8(input logic [63:0] p0, p1, p2, p3, p4, p5, p6, p7);
        return {p7, p6, p5, p4, p3, p2, p1, p0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bpl(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: every load must land in the c1=c3=0 phase and match the next expected snapshot.
    initial forever begin
        @(negedge clk);
        if (load_a === 1'b1) begin
            chk("load_a_phase", 64'(c1 | c3), 64'h0);
            if (exp_a_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL load_a_unexpected: got load with bpldata %0h, expected no load", bpl_a);
            end else begin
                chk_bpl("load_a_bpldata", bpl_a, exp_a_q.pop_front());
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (load_o === 1'b1) begin
            chk("load_o_phase", 64'(c1 | c3), 64'h0);
            if (exp_o_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL load_o_unexpected: got load with bpldata %0h, expected no load", bpl_o);
            end else begin
                chk_bpl("load_o_bpldata", bpl_o, exp_o_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One-cycle register write; p selects the phase of the write cycle (4 = any).
    task automatic wr(input bit to_a, input bit to_o, input logic [7:0] a,
                      input logic [63:0] d, input int p);
        while (p < 4 && int'(ph) != p) step();
        en_a = to_a;
        en_o = to_o;
        addr = a;
        data = d;
        step();
        en_a = 1'b0;
        en_o = 1'b0;
        addr = 8'h00;
        data = 64'h0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_a_q.size() != 0 || exp_o_q.size() != 0) && k < 40) begin
            step();
            k++;
        end
        n_checks++;
        if (exp_a_q.size() != 0 || exp_o_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d loads outstanding after 40 cycles, expected 0/0",
                     exp_a_q.size(), exp_o_q.size());
            exp_a_q.delete();
            exp_o_q.delete();
        end
        repeat (8) step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) step();
        chk_bpl("rst_bpldata", bpl_a, 512'h0);
        chk("rst_load", 64'(load_a), 64'h0);
        chk("rst_scroll_odd", 64'(so_a), 64'h0);
        chk("rst_scroll_even", 64'(se_a), 64'h0);
        chk("rst_hires", 64'(hires_a), 64'h0);
        chk("rst_shres", 64'(shres_a), 64'h0);
        chk("rst_fmode", 64'(fm_a), 64'h0);
        chk("rst_nplanes", 64'(np_a), 64'h0);
        reset = 1'b0;
        step();

        // Reset while a load is pending discards it.
        wr(1, 0, A_CON0, 64'h2000, 4);
        wr(1, 0, A_BPL1, 64'hAAAA, 0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_load", 64'(load_a), 64'h0);
        chk_bpl("midrst_bpldata", bpl_a, 512'h0);
        chk("midrst_nplanes", 64'(np_a), 64'h0);
        repeat (8) step();

        // 16-bit fetch, two planes.
        wr(1, 0, A_CON0, 64'h2000, 4);
        chk("np_two", 64'(np_a), 64'h2);
        wr(1, 0, A_BPL2, 64'h0F0F_0F0F_0F0F_BEEF, 4);
        wr(1, 0, A_BPL3, 64'h5555, 4);
        chk_bpl("bpl2_no_output", bpl_a, 512'h0);
        exp_a_q.push_back(mk8(pl(16'h1234), pl(16'hBEEF), 0, 0, 0, 0, 0, 0));
        wr(1, 0, A_BPL1, 64'hFFFF_FFFF_FFFF_1234, 0);
        drain();

        // 64-bit and 32-bit fetch, eight planes.
        wr(1, 0, A_CON0, 64'h0010, 4);
        chk("np_eight", 64'(np_a), 64'h8);
        wr(1, 0, A_FMOD, 64'h3, 4);
        chk("fmode_11", 64'(fm_a), 64'h3);
        exp_a_q.push_back(mk8(64'h0123_4567_89AB_CDEF, pl(16'hBEEF), pl(16'h5555), 0, 0, 0, 0, 0));
        wr(1, 0, A_BPL1, 64'h0123_4567_89AB_CDEF, 0);
        drain();
        wr(1, 0, A_FMOD, 64'h1, 4);
        exp_a_q.push_back(mk8(64'h89AB_CDEF_0000_0000, pl(16'hBEEF), pl(16'h5555), 0, 0, 0, 0, 0));
        wr(1, 0, A_BPL1, 64'h0123_4567_89AB_CDEF, 0);
        drain();

        // Two writes before the load window collapse to one load.
        wr(1, 0, A_FMOD, 64'h0, 4);
        chk("fmode_00", 64'(fm_a), 64'h0);
        exp_a_q.push_back(mk8(pl(16'h2222), pl(16'hBEEF), pl(16'h5555), 0, 0, 0, 0, 0));
        wr(1, 0, A_BPL1, 64'h1111, 0);
        wr(1, 0, A_BPL1, 64'h2222, 1);
        drain();

        // Write in the load cycle: old snapshot loads, then the new one.
        exp_a_q.push_back(mk8(pl(16'h3333), pl(16'hBEEF), pl(16'h5555), 0, 0, 0, 0, 0));
        exp_a_q.push_back(mk8(pl(16'h4444), pl(16'hBEEF), pl(16'h5555), 0, 0, 0, 0, 0));
        wr(1, 0, A_BPL1, 64'h3333, 0);
        wr(1, 0, A_BPL1, 64'h4444, 3);
        drain();

        // Plane count change while pending leaves the snapshot alone.
        exp_a_q.push_back(mk8(pl(16'h5A5A), pl(16'hBEEF), pl(16'h5555), 0, 0, 0, 0, 0));
        wr(1, 0, A_BPL1, 64'h5A5A, 0);
        wr(1, 0, A_CON0, 64'h2000, 2);
        chk("np_changed", 64'(np_a), 64'h2);
        drain();

        // Control decode, AGA.
        wr(1, 0, A_CON1, 64'hF3A5, 4);
        chk("aga_scroll_odd_f3a5", 64'(so_a), 64'h17);
        chk("aga_scroll_even_f3a5", 64'(se_a), 64'hEB);
        wr(1, 0, A_CON1, 64'h0C30, 4);
        chk("aga_scroll_odd_0c30", 64'(so_a), 64'hC0);
        chk("aga_scroll_even_0c30", 64'(se_a), 64'h0C);
        wr(1, 0, A_CON3, 64'hFFFF, 4);
        chk("ignored_addr_scroll", 64'(so_a), 64'hC0);
        wr(1, 0, A_CON0, 64'h8040, 4);
        chk("aga_hires", 64'(hires_a), 64'h1);
        chk("aga_shres", 64'(shres_a), 64'h1);
        chk("aga_np_zero", 64'(np_a), 64'h0);
        wr(1, 0, A_CON0, 64'h7010, 4);
        chk("aga_np_sat", 64'(np_a), 64'h8);
        chk("aga_hires_off", 64'(hires_a), 64'h0);

        // OCS instance.
        wr(0, 1, A_CON1, 64'hF3A5, 4);
        chk("ocs_scroll_odd", 64'(so_o), 64'h14);
        chk("ocs_scroll_even", 64'(se_o), 64'h28);
        wr(0, 1, A_CON0, 64'h0010, 4);
        chk("ocs_np_bpu3_ignored", 64'(np_o), 64'h0);
        wr(0, 1, A_CON0, 64'h7040, 4);
        chk("ocs_np_sat", 64'(np_o), 64'h6);
        chk("ocs_shres", 64'(shres_o), 64'h0);
        wr(0, 1, A_FMOD, 64'h3, 4);
        chk("ocs_fmode", 64'(fm_o), 64'h0);
        wr(0, 1, A_BPL7, 64'hFFFF, 4);
        wr(0, 1, A_BPL8, 64'hFFFF, 4);
        wr(0, 1, A_BPL6, 64'h6666, 4);
        exp_o_q.push_back(mk8(pl(16'h1357), 0, 0, 0, 0, pl(16'h6666), 0, 0));
        wr(0, 1, A_BPL1, 64'hFFFF_FFFF_FFFF_1357, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
